// File: rtl/repack_pkg.sv
// repack_pkg: shared widths and FSM state type for fifo_repacketizer.
package repack_pkg;
    localparam int BYTE_W = 8;
    localparam int LEN_W  = 8;
    typedef enum logic [1:0] {IDLE, PAYLOAD, CKSUM} state_t;
endpackage

// File: rtl/repack_word_assembler.sv
// repack_word_assembler: packs popped bytes into lanes of one output word with keep mask.
module repack_word_assembler
    import repack_pkg::*;
#(
    parameter int OUT_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start_i,
    input  logic                          wr_i,
    input  logic [BYTE_W-1:0]             byte_i,
    output logic [$clog2(OUT_BYTES)-1:0]  lane_o,
    output logic [BYTE_W*OUT_BYTES-1:0]   data_o,
    output logic [OUT_BYTES-1:0]          keep_o
);
    localparam int LW = $clog2(OUT_BYTES);
    localparam int DW = BYTE_W * OUT_BYTES;
    logic [LW-1:0]        lane_q, lane_d;
    logic [DW-1:0]        data_q, data_d;
    logic [OUT_BYTES-1:0] keep_q, keep_d;
    // A write into lane 0 always begins a fresh word, so stale lanes are dropped there.
    always_comb begin
        lane_d = start_i ? '0 : wr_i ? lane_q + LW'(1) : lane_q;
        data_d = wr_i ? ((lane_q == '0 ? '0 : data_q) | (DW'(byte_i) << {lane_q, 3'b000})) : data_q;
        keep_d = wr_i ? ((lane_q == '0 ? '0 : keep_q) | (OUT_BYTES'(1) << lane_q)) : keep_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            data_q <= '0;
            keep_q <= '0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
            keep_q <= keep_d;
        end
    end
    assign lane_o = lane_q;
    assign data_o = data_q;
    assign keep_o = keep_q;
endmodule

// File: rtl/fifo_repacketizer.sv
// fifo_repacketizer: length-prefixed byte packets from a FWFT FIFO into OUT_BYTES-wide words.
// Define REPACK_CHECKSUM_EN to expect and verify a trailing XOR checksum byte per packet.
module fifo_repacketizer
    import repack_pkg::*;
#(
    parameter int OUT_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [BYTE_W-1:0]           fifo_data,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    output logic [BYTE_W*OUT_BYTES-1:0] out_data,
    output logic [OUT_BYTES-1:0]        out_keep,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic                        out_err,
    output logic                        out_valid,
    input  logic                        out_ready
);
    localparam int LW = $clog2(OUT_BYTES);
`ifdef REPACK_CHECKSUM_EN
    localparam state_t TAIL = CKSUM;
`else
    localparam state_t TAIL = IDLE;
`endif
    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             sop_pend_q, sop_pend_d, valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [LW-1:0]    lane;
    logic             pop, hdr, wr, last, emit_mid, emit_end, emit;
`ifdef REPACK_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              zero_q, zero_d, err_q, err_d;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hdr) state_d = (fifo_data != '0) ? PAYLOAD : TAIL;
            PAYLOAD: if (wr && last) state_d = TAIL;
            default: if (pop) state_d = IDLE;
        endcase
    end
    // Pops are gated by reset so the FIFO is never drained while we are held in reset.
    always_comb begin
        pop      = reset_n && !fifo_empty && (!valid_q || out_ready);
        hdr      = pop && state_q == IDLE;
        wr       = pop && state_q == PAYLOAD;
        last     = rem_q == LEN_W'(1);
        emit_mid = wr && lane == LW'(OUT_BYTES - 1) && !last;
`ifdef REPACK_CHECKSUM_EN
        emit_end = pop && state_q == CKSUM && !zero_q;
`else
        emit_end = wr && last;
`endif
        emit     = emit_mid || emit_end;
    end
    always_comb begin
        rem_d      = hdr ? fifo_data : wr ? rem_q - LEN_W'(1) : rem_q;
        sop_pend_d = hdr || (sop_pend_q && !emit);
        valid_d    = emit || (valid_q && !out_ready);
        sop_d      = emit ? sop_pend_q : sop_q;
        eop_d      = emit ? emit_end : eop_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q      <= '0;
            sop_pend_q <= 1'b0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            sop_pend_q <= sop_pend_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
        end
    end
`ifdef REPACK_CHECKSUM_EN
    // Empty packets still carry a checksum byte; its verdict is dropped since no word is emitted.
    always_comb begin
        csum_d = hdr ? '0 : wr ? csum_q ^ fifo_data : csum_q;
        zero_d = hdr ? fifo_data == '0 : zero_q;
        err_d  = emit ? (emit_end && fifo_data != csum_q) : err_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            zero_q <= zero_d;
            err_q  <= err_d;
        end
    end
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif
    repack_word_assembler #(.OUT_BYTES(OUT_BYTES)) u_asm (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (hdr),
        .wr_i    (wr),
        .byte_i  (fifo_data),
        .lane_o  (lane),
        .data_o  (out_data),
        .keep_o  (out_keep)
    );
    assign fifo_rd_en = pop;
    assign out_valid  = valid_q;
    assign out_sop    = sop_q;
    assign out_eop    = eop_q;
endmodule

// File: tb/tb_fifo_repacketizer.sv
// tb_fifo_repacketizer: randomized and directed checks of fifo_repacketizer against a packet-level model.
module tb_fifo_repacketizer;
    localparam int OB = 4;
`ifdef REPACK_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    typedef struct packed {
        logic [8*OB-1:0] data;
        logic [OB-1:0]   keep;
        logic            sop;
        logic            eop;
        logic            err;
    } word_t;

    logic clk = 0, reset_n = 0, fifo_empty = 1, out_ready = 0;
    logic [7:0] fifo_data = 8'h00;
    logic fifo_rd_en, out_sop, out_eop, out_err, out_valid;
    logic [8*OB-1:0] out_data;
    logic [OB-1:0] out_keep;

    int tests = 0, fails = 0, cyc = 0, gap_pct = 0;
    bit rnd_ready = 0;
    logic [7:0] src[$];
    word_t exp_q[$], got_q[$];
    int acc_cyc[$];
    bit prev_stall = 0;
    word_t prev_w;

    always #5 clk = ~clk;

    fifo_repacketizer #(.OUT_BYTES(OB)) dut (
        .clk(clk), .reset_n(reset_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_keep(out_keep), .out_sop(out_sop),
        .out_eop(out_eop), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic word_t cur_word();
        return {out_data, out_keep, out_sop, out_eop, out_err};
    endfunction

    // Reference model: frame the packet into the FIFO and chunk its payload into expected words.
    task automatic add_packet(input logic [7:0] pl[$], input bit corrupt);
        logic [7:0] x;
        word_t w;
        int n;
        n = pl.size();
        x = 8'h00;
        src.push_back(8'(n));
        foreach (pl[i]) begin
            src.push_back(pl[i]);
            x ^= pl[i];
        end
        if (CK) src.push_back(corrupt ? ~x : x);
        for (int i = 0; i < n; i += OB) begin
            w = '0;
            for (int j = 0; j < OB; j++)
                if (i + j < n) begin
                    w.data[8*j +: 8] = pl[i+j];
                    w.keep[j] = 1'b1;
                end
            w.sop = (i == 0);
            w.eop = (i + OB >= n);
            w.err = CK && w.eop && corrupt;
            exp_q.push_back(w);
        end
    endtask

    task automatic cycle();
        word_t w;
        bit rd;
        @(negedge clk);
        cyc++;
        w = cur_word();
        tests++;
        if (fifo_rd_en !== (!fifo_empty && (!out_valid || out_ready))) begin
            fails++;
            $display("FAIL rd_en cyc %0d: got %b want %b", cyc, fifo_rd_en, !fifo_empty && (!out_valid || out_ready));
        end
        if (prev_stall) begin
            tests++;
            if (out_valid !== 1'b1 || w !== prev_w) begin
                fails++;
                $display("FAIL hold cyc %0d: got valid=%b word=%h want valid=1 word=%h", cyc, out_valid, w, prev_w);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_w = w;
        if (out_valid && out_ready) begin
            got_q.push_back(w);
            acc_cyc.push_back(cyc);
        end
        rd = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd && src.size() > 0) void'(src.pop_front());
        fifo_empty = (src.size() == 0) || ($urandom_range(99) < gap_pct);
        fifo_data = (src.size() > 0) ? src[0] : 8'h00;
        if (rnd_ready) out_ready = 1'($urandom_range(1));
    endtask

    task automatic begin_test();
        exp_q.delete();
        got_q.delete();
        acc_cyc.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((src.size() > 0 || out_valid) && n < 20000) begin
            cycle();
            n++;
        end
        repeat (4) cycle();
        tests++;
        if (n >= 20000) begin
            fails++;
            $display("FAIL %s timeout: got %0d cycles want < 20000", name, n);
        end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s word count: got %0d want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s word[%0d]: got %h want %h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        fifo_empty = 1;
        out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests += 7;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset valid: got %b want 0", out_valid); end
        if (out_data !== '0) begin fails++; $display("FAIL reset data: got %h want 0", out_data); end
        if (out_keep !== '0) begin fails++; $display("FAIL reset keep: got %b want 0", out_keep); end
        if (out_sop !== 1'b0) begin fails++; $display("FAIL reset sop: got %b want 0", out_sop); end
        if (out_eop !== 1'b0) begin fails++; $display("FAIL reset eop: got %b want 0", out_eop); end
        if (out_err !== 1'b0) begin fails++; $display("FAIL reset err: got %b want 0", out_err); end
        if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset rd_en: got %b want 0", fifo_rd_en); end
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [7:0] p[$];
        word_t e;
        begin_test();
        rnd_ready = 0; out_ready = 1; gap_pct = 0;
        p = {8'h11, 8'h22, 8'h33, 8'h44};
        add_packet(p, 0);
        drain("single");
        e = {32'h44332211, 4'b1111, 1'b1, 1'b1, 1'b0};
        tests++;
        if (got_q.size() < 1 || got_q[0] !== e) begin
            fails++;
            $display("FAIL single literal: got %h want %h", got_q.size() ? got_q[0] : '0, e);
        end
    endtask

    task automatic test_two_words();
        logic [7:0] p[$];
        word_t e0, e1;
        begin_test();
        out_ready = 1; gap_pct = 0;
        p = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        add_packet(p, 0);
        drain("two_words");
        e0 = {32'h04030201, 4'b1111, 1'b1, 1'b0, 1'b0};
        e1 = {32'h00000605, 4'b0011, 1'b0, 1'b1, 1'b0};
        tests += 2;
        if (got_q.size() < 2 || got_q[0] !== e0 || got_q[1] !== e1) begin
            fails++;
            $display("FAIL two_words literal: got %0d words want %h %h", got_q.size(), e0, e1);
        end
        if (got_q.size() == 2 && got_q[1].keep !== 4'b0011) begin
            fails++;
            $display("FAIL two_words keep: got %b want 0011", got_q[1].keep);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] p[$];
        int n = 0;
        begin_test();
        out_ready = 0; gap_pct = 0;
        p = {8'h11, 8'h22, 8'h33, 8'h44};
        add_packet(p, 0);
        p = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        add_packet(p, 0);
        while (!out_valid && n < 50) begin cycle(); n++; end
        tests++;
        if (n >= 50) begin fails++; $display("FAIL stall wait: got %0d cycles want < 50", n); end
        repeat (5) begin
            cycle();
            tests++;
            if (fifo_rd_en !== 1'b0 || out_data !== 32'h44332211) begin
                fails++;
                $display("FAIL stall hold: got rd_en=%b data=%h want rd_en=0 data=44332211", fifo_rd_en, out_data);
            end
        end
        out_ready = 1;
        drain("backpressure");
        tests += 2;
        if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 5) begin
            fails++;
            $display("FAIL b2b header gap: got %0d want 5", acc_cyc.size() == 3 ? acc_cyc[1] - acc_cyc[0] : -1);
        end
        if (acc_cyc.size() != 3 || acc_cyc[2] - acc_cyc[1] != (CK ? 5 : 4)) begin
            fails++;
            $display("FAIL b2b word gap: got %0d want %0d", acc_cyc.size() == 3 ? acc_cyc[2] - acc_cyc[1] : -1, CK ? 5 : 4);
        end
    endtask

    task automatic test_empty_packet();
        logic [7:0] p[$];
        word_t e;
        begin_test();
        out_ready = 1; gap_pct = 40;
        p = {};
        add_packet(p, 0);
        p = {8'h7E};
        add_packet(p, 0);
        p = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0};
        add_packet(p, 0);
        drain("empty_pkt");
        gap_pct = 0;
        e = {32'h0000007E, 4'b0001, 1'b1, 1'b1, 1'b0};
        tests++;
        if (got_q.size() < 1 || got_q[0] !== e) begin
            fails++;
            $display("FAIL empty_pkt literal: got %h want %h", got_q.size() ? got_q[0] : '0, e);
        end
    endtask

`ifdef REPACK_CHECKSUM_EN
    task automatic test_checksum();
        begin_test();
        out_ready = 1; gap_pct = 0;
        src = {8'h02, 8'hAA, 8'h55, 8'hFF, 8'h02, 8'hAA, 8'h55, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h05, 8'h01, 8'h7E, 8'h7E};
        exp_q.push_back({32'h000055AA, 4'b0011, 1'b1, 1'b1, 1'b0});
        exp_q.push_back({32'h000055AA, 4'b0011, 1'b1, 1'b1, 1'b1});
        exp_q.push_back({32'h0000007E, 4'b0001, 1'b1, 1'b1, 1'b0});
        drain("checksum");
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] p[$];
        word_t e;
        begin_test();
        out_ready = 1; gap_pct = 0;
        p = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        add_packet(p, 0);
        repeat (4) cycle();
        tests++;
        if (out_keep !== 4'b0011) begin fails++; $display("FAIL mid partial keep: got %b want 0011", out_keep); end
        #2 reset_n = 0;
        #1;
        tests += 4;
        if (out_keep !== '0) begin fails++; $display("FAIL async keep: got %b want 0", out_keep); end
        if (out_data !== '0) begin fails++; $display("FAIL async data: got %h want 0", out_data); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL async valid: got %b want 0", out_valid); end
        if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL async rd_en: got %b want 0", fifo_rd_en); end
        src.delete();
        fifo_empty = 1;
        prev_stall = 0;
        begin_test();
        @(negedge clk);
        reset_n = 1;
        p = {8'h11, 8'h22, 8'h33, 8'h44};
        add_packet(p, 0);
        drain("after_reset");
        e = {32'h44332211, 4'b1111, 1'b1, 1'b1, 1'b0};
        tests++;
        if (got_q.size() < 1 || got_q[0] !== e) begin
            fails++;
            $display("FAIL after_reset literal: got %h want %h", got_q.size() ? got_q[0] : '0, e);
        end
    endtask

    task automatic test_random();
        logic [7:0] p[$];
        int n;
        begin_test();
        rnd_ready = 1; gap_pct = 20;
        for (int k = 0; k < 40; k++) begin
            n = (k == 20) ? 255 : int'($urandom_range(16));
            p.delete();
            for (int i = 0; i < n; i++) p.push_back(8'($urandom));
            add_packet(p, $urandom_range(3) == 0);
        end
        drain("random");
        rnd_ready = 0; out_ready = 1; gap_pct = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_words();
        test_backpressure();
        test_empty_packet();
`ifdef REPACK_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_repacketizer.md
# fifo_repacketizer

Byte-stream-to-word repacketizer on the read side of the asynchronous byte FIFO. It pops length-prefixed byte packets from the FIFO read port and packs each payload into OUT_BYTES-wide words. It presents those words on a valid/ready stream with start-of-packet, end-of-packet and byte-keep markers. It runs entirely in the FIFO read-clock domain.

## Interface
- OUT_BYTES, 4: bytes per output word; power of two, 2..16.
- LEN_WIDTH, 8: width of the packet length header byte(s); fixed at 8, one header byte.
- clk  input  1  FIFO read-side clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- fifo_data  input  8  FIFO head byte; valid whenever fifo_empty=0 (first-word fall-through).
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  pop strobe; one byte consumed per cycle asserted.
- out_data  output  8*OUT_BYTES  packed word; first byte of word in bits [7:0].
- out_keep  output  OUT_BYTES  valid-lane mask, contiguous from lane 0.
- out_sop  output  1  first word of packet.
- out_eop  output  1  last word of packet.
- out_err  output  1  checksum mismatch, meaningful only with out_eop (see Configuration).
- out_valid  output  1  word available.
- out_ready  input  1  downstream accepts word when out_valid && out_ready.

## Operation
- Framing: header byte L (payload length 0..255), then L payload bytes, then (if configured) one checksum byte.
- States: IDLE (await header), PAYLOAD (bytes remaining > 0), CKSUM (configured only), then back to IDLE.
- IDLE: pop header when fifo_empty=0 and no output word is pending. If L=0, stay in IDLE and produce no output. Otherwise load remaining=L, lane=0, set sop_pending=1, and go to PAYLOAD.
- PAYLOAD: each pop writes fifo_data into lane `lane` and sets keep[lane]. remaining decrements; lane increments modulo OUT_BYTES.
- The word completes when lane = OUT_BYTES-1 or remaining = 1. On completion, out_valid is set. out_sop takes the value of sop_pending, which then clears. out_eop is set when remaining = 1.
- Unused lanes of a partial last word read as 0. out_keep is cleared when a new word starts.
- Pop condition: fifo_rd_en = !fifo_empty && state ∈ {IDLE, PAYLOAD, CKSUM} && (!out_valid || out_ready). It is combinational.
- Accepting a word and popping the next byte may occur in the same cycle. The register reloads lane 0 with the new byte and clears the other lanes.
- fifo_empty mid-packet: pause with no pops; state and partial word are held.
- Arithmetic: remaining is 8 bits and never underflows. lane is $clog2(OUT_BYTES) bits and wraps.

## Timing
- Reset values: fifo_rd_en=0, out_valid=0, out_data=0, out_keep=0, out_sop=0, out_eop=0, out_err=0, state=IDLE.
- Reset mid-packet discards the partial word and state. The upstream FIFO is reset by its own control.
- Latency: byte popped at edge N appears in out_data after edge N; out_valid rises after the edge that pops the word's last byte.
- Throughput: 1 byte/cycle sustained under out_ready=1. Header and checksum each cost one cycle.
- out_data, out_keep, out_sop, out_eop and out_err hold stable while out_valid && !out_ready.

## Configuration
- REPACK_CHECKSUM_EN defined: after the last payload byte, go to CKSUM and pop one byte. The popped byte is compared with the XOR of all payload bytes. out_eop and out_valid are asserted after the checksum pop, not after the last payload byte. out_err=1 on mismatch, 0 on match.
- For L=0, the checksum byte is still popped and must equal 0x00. No word is emitted and the error is dropped.
- REPACK_CHECKSUM_EN undefined: no CKSUM state and no checksum byte in framing. out_err is tied 0.

## Structure
- Package repack_pkg: state enum (IDLE, PAYLOAD, CKSUM), BYTE_W=8, LEN_W=8.
- Sub-module repack_word_assembler: lane register, keep mask, lane counter, and load/clear-on-accept logic. The FSM, pop logic and checksum stay in the top module.

## Test plan
- Reset asserted mid-packet -> all outputs 0 immediately (asynchronous). After release, the next header is parsed cleanly.
- OUT_BYTES=4, stream 04 11 22 33 44 -> one word: out_data=0x44332211, keep=1111, sop=1, eop=1.
- Stream 06 01 02 03 04 05 06 -> two words:
  - first: 0x04030201, keep=1111, sop=1, eop=0;
  - second: 0x00000605, keep=0011, sop=0, eop=1.
- out_ready=0 for 5 cycles with a word valid -> fifo_rd_en=0 and out_data stable; no byte lost or duplicated. Back-to-back accept+pop gives no bubble.
- Header 00, then 01 7E -> no word for the empty packet. The second packet yields 0x0000007E with keep=0001, sop=1, eop=1. fifo_empty pulsed mid-packet pauses without corruption.
- REPACK_CHECKSUM_EN: 02 AA 55 FF -> eop word 0x000055AA with err=0. 02 AA 55 00 -> err=1.
